scan_sel_gen: RTL and testbench
===============================

# scan_sel_gen

Sequential select generator that drives the enable and 3-bit select inputs of the 3-to-8 decoder (`decoder38`). It cycles through the eight decoder outputs, for example to scan an 8-digit display or an 8-way strobe bus. A per-position mask lets it skip positions, and it supports either free-running or single-step operation. Each position is held enabled for a programmable number of cycles, followed by an optional enable-low blanking gap.

## Interface
- DIV, default 4: cycles EN stays high per position; legal range 1..255.
- BLANK, default 1: cycles EN stays low between positions; legal range 0..255.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high. One clock; reset is synchronous and active-high.
- run  in  1  level; continuous scanning while high.
- step  in  1  single-cycle pulse; advances one position, honoured only in IDLE with run=0.
- mask  in  8  bit i=1 makes position i eligible; sampled only at advance points.
- EN  out  1  decoder enable, registered.
- Sel  out  3  decoder select {Ip2,Ip1,Ip0}, registered.
- wrap  out  1  one-cycle pulse marking the start of a frame.

## Operation
- Next-position function N(p):
  - Smallest set bit of mask strictly above p, searching cyclically mod 8.
  - If the only set bit is p, N(p)=p.
- Advance: on the edge where the block enters SHOW, Sel<=N(Sel) and wrap<=1 if N(Sel)<=Sel; otherwise wrap<=0.
- Reset state: IDLE, EN=0, Sel=3'b111, wrap=0, counters 0.
  - Because Sel resets to 7, the first advance after reset selects the lowest set bit and pulses wrap.
- Counter: a single 8-bit down counter serves both SHOW and BLANK. Width must hold 255.
- States:
  - IDLE: EN=0, Sel held.
    - If mask!=0 and (run=1 or step=1), advance and go to SHOW.
    - Otherwise stay in IDLE.
    - A step pulse with mask=0 is dropped.
  - SHOW: EN=1 for exactly DIV cycles. At the last cycle:
    - mask==0: go to IDLE; no blank is inserted.
    - BLANK>0: go to BLANK.
    - BLANK==0 and run=1: advance and stay in SHOW. EN stays high continuously while Sel changes.
    - BLANK==0 and run=0: go to IDLE.
  - BLANK: EN=0, Sel held, for exactly BLANK cycles. At the last cycle:
    - run=1 and mask!=0: advance and go to SHOW.
    - Otherwise: go to IDLE.
- step is ignored outside IDLE, and ignored when run=1. In step mode each pulse yields one SHOW (plus BLANK if BLANK>0), then IDLE.
- Deasserting run mid-position: the current SHOW and BLANK complete, then the block goes to IDLE. The position is never truncated.
- Mask changes mid-position take effect at the next advance only. The current position finishes even if its mask bit has been cleared.
- rst mid-operation: at the next edge all outputs and state return to reset values, regardless of state.

## Timing
- run or step sampled high at edge t: EN=1 and the new Sel are valid from edge t+1.
- Free-running period per position is DIV+BLANK cycles. A full frame with k active bits is k·(DIV+BLANK) cycles.
- wrap is high for exactly the first cycle of a SHOW. It is never asserted in IDLE or BLANK.
- Sel changes only on the edge entering SHOW, so with BLANK>0 it is stable throughout every EN-high window.
- No combinational path from any input to any output.

## Test plan
1. Reset: rst=1 for 2 cycles with run=1 and mask=FF -> EN=0, Sel=7, wrap=0. The first SHOW (Sel=0, wrap=1) begins one edge after rst falls.
2. DIV=4, BLANK=1, mask=FF, run=1 held:
   - Sel sequence is 0,1,…,7,0.
   - Each position shows EN high for 4 cycles, then EN low for 1 cycle.
   - wrap pulses at Sel=0 only; frame length is 40 cycles.
3. mask=8'b1010_0100, run=1 -> Sel sequence 2,5,7,2,…, with wrap at each entry to 2. mask=8'b0001_0000 -> Sel stays 4 and wrap pulses every 5 cycles.
4. Step mode (run=0), DIV=4, BLANK=1, mask=FF:
   - Three step pulses spaced 10 cycles apart -> positions 0, 1, 2 each shown for 4 cycles, then IDLE with Sel held at 2.
   - A step pulse issued during SHOW is ignored.
5. DIV=1, BLANK=0, mask=FF, run=1 -> EN constantly 1 and Sel increments every cycle, wrapping 7->0 with a wrap pulse.
6. Mid-operation events:
   - mask->0 during SHOW: the position completes, then EN=0 and the block stays in IDLE despite run=1.
   - run->0 in the middle of the 2nd SHOW cycle: 4 EN-high cycles, 1 blank cycle, then IDLE.
   - rst=1 in the middle of SHOW: EN=0 and Sel=7 at the next edge.

Source files
------------

// File: rtl/scan_sel_gen.sv
// Scan select generator for a 3-to-8 decoder: walks the masked positions,
// holding EN high for DIV cycles per position with an optional BLANK gap.
module scan_sel_gen #(
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic [7:0] mask,
    output logic       EN,
    output logic [2:0] Sel,
    output logic       wrap
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHOW  = 2'd1;
    localparam logic [1:0] S_BLANK = 2'd2;

    localparam logic [7:0] DIV_M1   = 8'(DIV - 1);
    localparam logic [7:0] BLANK_M1 = 8'(BLANK - 1);

    logic [1:0] state;
    logic [7:0] cnt;
    logic [2:0] nxt;
    logic [2:0] idx;
    logic       found;
    logic       nxt_wrap;
    logic       mask_any;

    assign mask_any = |mask;

    // Cyclic search upward from Sel; offset 8 lands back on Sel itself,
    // so a lone set bit at the current position selects it again.
    always_comb begin
        nxt   = Sel;
        idx   = Sel;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = Sel + 3'(i);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        nxt_wrap = (nxt <= Sel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            EN    <= 1'b0;
            Sel   <= 3'b111;
            wrap  <= 1'b0;
            cnt   <= 8'd0;
        end else begin
            wrap <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mask_any && (run || step)) begin
                        state <= S_SHOW;
                        EN    <= 1'b1;
                        Sel   <= nxt;
                        wrap  <= nxt_wrap;
                        cnt   <= DIV_M1;
                    end
                end
                S_SHOW: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (!mask_any) begin
                        state <= S_IDLE;
                        EN    <= 1'b0;
                    end else if (BLANK > 0) begin
                        state <= S_BLANK;
                        EN    <= 1'b0;
                        cnt   <= BLANK_M1;
                    end else if (run) begin
                        // back-to-back positions: EN stays high while Sel moves
                        Sel  <= nxt;
                        wrap <= nxt_wrap;
                        cnt  <= DIV_M1;
                    end else begin
                        state <= S_IDLE;
                        EN    <= 1'b0;
                    end
                end
                S_BLANK: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (run && mask_any) begin
                        state <= S_SHOW;
                        EN    <= 1'b1;
                        Sel   <= nxt;
                        wrap  <= nxt_wrap;
                        cnt   <= DIV_M1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    EN    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed bench for scan_sel_gen: one instance at DIV=4/BLANK=1 and one at
// DIV=1/BLANK=0 share stimulus; outputs are sampled on the falling edge.
module tb_scan_sel_gen;

    logic       clk = 1'b0;
    logic       rst, run, step;
    logic [7:0] mask;
    logic       en_a, wrap_a, en_b, wrap_b;
    logic [2:0] sel_a, sel_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    scan_sel_gen #(.DIV(4), .BLANK(1)) u_dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .mask(mask),
        .EN(en_a), .Sel(sel_a), .wrap(wrap_a)
    );

    scan_sel_gen #(.DIV(1), .BLANK(0)) u_dut_fast (
        .clk(clk), .rst(rst), .run(run), .step(step), .mask(mask),
        .EN(en_b), .Sel(sel_b), .wrap(wrap_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_a(input string tag, input logic e, input logic [2:0] s, input logic w);
        chk({tag, ".en"},   32'(en_a),   32'(e));
        chk({tag, ".sel"},  32'(sel_a),  32'(s));
        chk({tag, ".wrap"}, 32'(wrap_a), 32'(w));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_a("rst", 1'b0, 3'd7, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] seq3 [3];
        seq3[0] = 3'd2; seq3[1] = 3'd5; seq3[2] = 3'd7;
        step = 1'b0;

        // reset with run held, then free-run mask=FF (fast instance checked too)
        run = 1'b1; mask = 8'hFF;
        do_reset();
        chk("rst_fast.en",  32'(en_b),  32'd0);
        chk("rst_fast.sel", 32'(sel_b), 32'd7);
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            chk_a("ff", (c % 5) < 4, 3'((c / 5) % 8), ((c % 5) == 0) && ((c / 5) % 8 == 0));
            chk("fast.en",   32'(en_b),   32'd1);
            chk("fast.sel",  32'(sel_b),  32'(c % 8));
            chk("fast.wrap", 32'(wrap_b), 32'((c % 8) == 0));
        end

        // sparse mask 2,5,7
        run = 1'b0;
        do_reset();
        mask = 8'b1010_0100; run = 1'b1;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            chk_a("sparse", (c % 5) < 4, seq3[(c / 5) % 3], ((c % 5) == 0) && ((c / 5) % 3 == 0));
        end

        // single bit: Sel stays 4, wrap every 5 cycles
        run = 1'b0;
        do_reset();
        mask = 8'b0001_0000; run = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            chk_a("single", (c % 5) < 4, 3'd4, (c % 5) == 0);
        end

        // step mode, with an extra step during the first SHOW that must be ignored
        run = 1'b0;
        do_reset();
        mask = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                step = (k == 0 && c == 1);
                chk_a("step", c < 4, 3'(k), (k == 0) && (c == 0));
            end
        end
        step = 1'b0;

        // step with mask=0 is dropped
        mask = 8'h00; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        chk_a("step_nomask", 1'b0, 3'd2, 1'b0);

        // mask cleared during SHOW: position completes, then IDLE despite run
        do_reset();
        mask = 8'hFF; run = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 1) mask = 8'h00;
            chk_a("mask0", c < 4, 3'd0, c == 0);
        end

        // run dropped in the 2nd SHOW cycle: 4 shown, 1 blank, then IDLE
        run = 1'b0;
        do_reset();
        mask = 8'hFF; run = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 1) run = 1'b0;
            chk_a("runoff", c < 4, 3'd0, c == 0);
        end

        // reset in the middle of SHOW
        do_reset();
        run = 1'b1;
        @(negedge clk);
        chk_a("pre_rst", 1'b1, 3'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_a("mid_rst", 1'b0, 3'd7, 1'b0);
        rst = 1'b0; run = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
